bcm_row_sequencer: RTL and testbench

Initiator side of the panel output-enable timing interface. Steps through bit planes and rows for binary-coded-modulation display, and requests column shifts from the column shifter. Issues row_latch pulses and drives the one-hot brightness_mask_active and row_address consumed by the brightness timeout block. Uses that block's output_enable (running) as the handshake that a display period has finished before the next latch.

---
 rtl/bcm_row_sequencer.sv | 141 ++++++++++++++
 tb/tb_bcm_row_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcm_row_sequencer.sv
// Binary-coded-modulation row/plane sequencer: requests column shifts, strobes row_latch
// and hands each display period to the OE timeout block. Optional macro: BCM_OE_WATCHDOG_EN.
module bcm_row_sequencer #(
    parameter int unsigned N               = 8,
    parameter int unsigned ROW_BITS        = 4,
    parameter int unsigned LATCH_CYCLES    = 2,
    parameter int unsigned WATCHDOG_CYCLES = 4096
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                enable,
    input  logic                shift_done,
    input  logic                output_enable,
    output logic                shift_start,
    output logic                row_latch,
    output logic [N-1:0]        brightness_mask_active,
    output logic [ROW_BITS-1:0] row_address,
    output logic                frame_start,
    output logic                oe_fault
);

    localparam int unsigned PLANE_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LAT_W   = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_REQ,
        SHIFT_WAIT,
        OE_WAIT,
        LATCH
    } state_t;

    state_t              state;
    logic [PLANE_W-1:0]  plane_ptr;
    logic [ROW_BITS-1:0] row_ptr;
    logic [LAT_W-1:0]    lat_cnt;
    logic                oe_pending;
    logic                wd_expire;

    // Elaboration guard on parameter ranges
    if (LATCH_CYCLES < 1 || WATCHDOG_CYCLES < 1) begin : g_bad_param
        $error("bcm_row_sequencer: LATCH_CYCLES and WATCHDOG_CYCLES must be >= 1");
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state                  <= IDLE;
            shift_start            <= 1'b0;
            row_latch              <= 1'b0;
            brightness_mask_active <= '0;
            row_address            <= '0;
            frame_start            <= 1'b0;
            plane_ptr              <= '0;
            row_ptr                <= '0;
            lat_cnt                <= '0;
            oe_pending             <= 1'b0;
        end else begin
            shift_start <= 1'b0;
            frame_start <= 1'b0;
            // Any visible OE activity retires the pending display, even while shifting
            if (output_enable || wd_expire) begin
                oe_pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state       <= SHIFT_REQ;
                        shift_start <= 1'b1;
                    end
                end
                SHIFT_REQ: state <= SHIFT_WAIT;
                SHIFT_WAIT: begin
                    if (shift_done) begin
                        state <= OE_WAIT;
                    end
                end
                OE_WAIT: begin
                    if (!output_enable && !oe_pending) begin
                        state                  <= LATCH;
                        row_latch              <= 1'b1;
                        lat_cnt                <= '0;
                        brightness_mask_active <= N'(1) << plane_ptr;
                        row_address            <= row_ptr;
                        frame_start            <= (row_ptr == '0) && (plane_ptr == '0);
                        if (plane_ptr == PLANE_W'(N - 1)) begin
                            plane_ptr <= '0;
                            row_ptr   <= row_ptr + ROW_BITS'(1);
                        end else begin
                            plane_ptr <= plane_ptr + PLANE_W'(1);
                        end
                    end
                end
                LATCH: begin
                    if (lat_cnt == LAT_W'(LATCH_CYCLES - 1)) begin
                        row_latch  <= 1'b0;
                        oe_pending <= 1'b1;
                        if (enable) begin
                            state       <= SHIFT_REQ;
                            shift_start <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            plane_ptr <= '0;
                            row_ptr   <= '0;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BCM_OE_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;

    assign wd_expire = oe_pending && (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1));

    // Counts cycles a display period has been owed but not seen; fault is sticky
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            wd_cnt   <= '0;
            oe_fault <= 1'b0;
        end else if (!oe_pending) begin
            wd_cnt <= '0;
        end else if (wd_expire) begin
            wd_cnt   <= '0;
            oe_fault <= 1'b1;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end
`else
    assign wd_expire = 1'b0;
    assign oe_fault  = 1'b0;
`endif

endmodule

// File: tb/tb_bcm_row_sequencer.sv
// Scoreboard bench for bcm_row_sequencer: expected latches are queued by the stimulus
// and checked by a monitor on every row_latch rise. Honours BCM_OE_WATCHDOG_EN.
module tb_bcm_row_sequencer;

    localparam int unsigned N               = 4;
    localparam int unsigned ROW_BITS        = 2;
    localparam int unsigned LATCH_CYCLES    = 2;
    localparam int unsigned WATCHDOG_CYCLES = 64;

`ifdef BCM_OE_WATCHDOG_EN
    localparam logic WD_EXP      = 1'b1;
    localparam int   EXP_LATCHES = 23;
`else
    localparam logic WD_EXP      = 1'b0;
    localparam int   EXP_LATCHES = 22;
`endif

    localparam logic [N-1:0] WRAP_MASK [17] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8,
                                                4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8,
                                                4'h1};
    localparam logic [ROW_BITS-1:0] WRAP_ROW [17] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                                                      2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3,
                                                      2'd0};

    typedef struct {
        logic [N-1:0]        mask;
        logic [ROW_BITS-1:0] row;
        logic                frame;
    } exp_t;

    logic                clk_in = 1'b0;
    logic                reset = 1'b0;
    logic                enable = 1'b0;
    logic                shift_done = 1'b0;
    logic                output_enable = 1'b0;
    logic                shift_start;
    logic                row_latch;
    logic [N-1:0]        brightness_mask_active;
    logic [ROW_BITS-1:0] row_address;
    logic                frame_start;
    logic                oe_fault;

    exp_t        exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          n_latch = 0;
    int          sh_cnt = 0;
    int          oe_mode = 0;
    bit          bp_pending = 1'b0;
    int unsigned cyc = 0;
    int unsigned oe_fall_cyc = 0;

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    bcm_row_sequencer #(
        .N               (N),
        .ROW_BITS        (ROW_BITS),
        .LATCH_CYCLES    (LATCH_CYCLES),
        .WATCHDOG_CYCLES (WATCHDOG_CYCLES)
    ) dut (
        .clk_in                 (clk_in),
        .reset                  (reset),
        .enable                 (enable),
        .shift_done             (shift_done),
        .output_enable          (output_enable),
        .shift_start            (shift_start),
        .row_latch              (row_latch),
        .brightness_mask_active (brightness_mask_active),
        .row_address            (row_address),
        .frame_start            (frame_start),
        .oe_fault               (oe_fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    endtask

    task automatic push(input logic [N-1:0] m, input logic [ROW_BITS-1:0] r, input logic f);
        exp_t e;
        e.mask  = m;
        e.row   = r;
        e.frame = f;
        exp_q.push_back(e);
    endtask

    task automatic wait_q(input int budget, input int depth, input string name);
        int i = 0;
        while (exp_q.size() > depth && i < budget) begin
            @(negedge clk_in);
            i++;
        end
        check(name, 32'(exp_q.size() <= depth), 1);
    endtask

    task automatic wait_shift(input int budget, input string name);
        int i = 0;
        do begin
            @(negedge clk_in);
            i++;
        end while (!shift_start && i < budget);
        check(name, 32'(shift_start), 1);
    endtask

    // Column shifter model: shift_done three cycles after each request
    initial begin
        forever begin
            @(negedge clk_in);
            if (reset && shift_start) begin
                repeat (2) @(negedge clk_in);
                shift_done = 1'b1;
                @(negedge clk_in);
                shift_done = 1'b0;
            end
        end
    end

    // OE timeout model: display period starts when row_latch falls
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk_in);
            if (reset && prev && !row_latch) begin
                case (oe_mode)
                    1: begin
                        oe_mode = 0;
                        output_enable = 1'b1;
                        repeat (50) @(negedge clk_in);
                        output_enable = 1'b0;
                        oe_fall_cyc = cyc;
                        bp_pending = 1'b1;
                    end
                    2: begin
                        oe_mode = 0;
                        repeat (WATCHDOG_CYCLES - 1) @(negedge clk_in);
                        check("oe_fault_before_timeout", 32'(oe_fault), 0);
                        @(negedge clk_in);
                        check("oe_fault_at_timeout", 32'(oe_fault), 32'(WD_EXP));
                    end
                    default: begin
                        output_enable = 1'b1;
                        repeat (10 * int'(brightness_mask_active)) @(negedge clk_in);
                        output_enable = 1'b0;
                    end
                endcase
            end
            prev = reset ? row_latch : 1'b0;
        end
    end

    // Monitor: every row_latch rise pops one expectation
    initial begin
        logic prev;
        int   width;
        exp_t e;
        prev  = 1'b0;
        width = 0;
        forever begin
            @(negedge clk_in);
            if (!reset) begin
                prev   = 1'b0;
                width  = 0;
                sh_cnt = 0;
            end else begin
                if (shift_start) sh_cnt++;
                if (row_latch && !prev) begin
                    n_latch++;
                    width = 1;
                    check("shift_start_per_latch", 32'(sh_cnt), 1);
                    sh_cnt = 0;
                    check("latch_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("latch_mask", 32'(brightness_mask_active), 32'(e.mask));
                        check("latch_row", 32'(row_address), 32'(e.row));
                        check("latch_frame_start", 32'(frame_start), 32'(e.frame));
                    end
                    // row_latch is high in the cycle after the first low OE cycle
                    if (bp_pending) begin
                        check("oe_release_to_latch", cyc - oe_fall_cyc, 1);
                        bp_pending = 1'b0;
                    end
                end else if (row_latch) begin
                    width++;
                end else if (prev) begin
                    check("latch_width", 32'(width), LATCH_CYCLES);
                end
                prev = row_latch;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk_in);
        check("rst_row_latch", 32'(row_latch), 0);
        check("rst_shift_start", 32'(shift_start), 0);
        check("rst_mask", 32'(brightness_mask_active), 0);
        check("rst_row", 32'(row_address), 0);
        check("rst_frame_start", 32'(frame_start), 0);
        check("rst_oe_fault", 32'(oe_fault), 0);
        reset = 1'b1;

        // Plane/row order and wrap over 17 latches
        @(negedge clk_in);
        for (int i = 0; i < 17; i++) push(WRAP_MASK[i], WRAP_ROW[i], 1'(i == 0 || i == 16));
        enable = 1'b1;
        @(negedge clk_in);
        check("idle_to_shift_start", 32'(shift_start), 1);
        wait_q(3000, 0, "wrap_sequence_done");
        enable = 1'b0;
        repeat (60) @(negedge clk_in);
        check("mask_hold_after_stop", 32'(brightness_mask_active), 32'h1);
        check("row_hold_after_stop", 32'(row_address), 0);

        // OE back-pressure, then enable drop while waiting for the shift
        oe_mode = 1;
        push(4'h1, 2'd0, 1'b1);
        push(4'h2, 2'd0, 1'b0);
        enable = 1'b1;
        wait_q(100, 1, "bp_first_latch");
        wait_shift(20, "bp_next_shift");
        @(negedge clk_in);
        enable = 1'b0;
        wait_q(200, 0, "bp_second_latch");
        repeat (100) @(negedge clk_in);
        check("mask_hold_after_drop", 32'(brightness_mask_active), 32'h2);
        check("row_hold_after_drop", 32'(row_address), 0);
        check("no_shift_after_drop", 32'(sh_cnt), 0);

        // Display period that never starts
        oe_mode = 2;
        push(4'h1, 2'd0, 1'b1);
`ifdef BCM_OE_WATCHDOG_EN
        push(4'h2, 2'd0, 1'b0);
        enable = 1'b1;
        wait_q(400, 0, "watchdog_recovery_latch");
        enable = 1'b0;
        repeat (60) @(negedge clk_in);
        check("oe_fault_sticky", 32'(oe_fault), 1);
`else
        enable = 1'b1;
        wait_q(100, 0, "pre_watchdog_latch");
        repeat (200) @(negedge clk_in);
        check("oe_fault_tied_low", 32'(oe_fault), 0);
        enable = 1'b0;
`endif
        @(negedge clk_in);
        reset = 1'b0;
        @(negedge clk_in);
        reset = 1'b1;

        // Asynchronous reset in the middle of a latch
        push(4'h1, 2'd0, 1'b1);
        enable = 1'b1;
        wait_q(100, 0, "pre_reset_latch");
        check("latch_high_before_reset", 32'(row_latch), 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_row_latch", 32'(row_latch), 0);
        check("async_rst_shift_start", 32'(shift_start), 0);
        check("async_rst_mask", 32'(brightness_mask_active), 0);
        check("async_rst_row", 32'(row_address), 0);
        check("async_rst_frame_start", 32'(frame_start), 0);
        @(negedge clk_in);
        #1 reset = 1'b1;
        push(4'h1, 2'd0, 1'b1);
        @(negedge clk_in);
        check("release_to_shift_start", 32'(shift_start), 1);
        wait_q(100, 0, "post_reset_latch");
        enable = 1'b0;
        repeat (40) @(negedge clk_in);
        check("latch_count", 32'(n_latch), 32'(EXP_LATCHES));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
